// File: rtl/bit_cldiv_pkg.sv
// Shared types and helpers for the carry-less divider.
package bit_cldiv_pkg;

  localparam int CLDIV_XLEN  = 32;
  localparam int CLDIV_CNT_W = $clog2(CLDIV_XLEN);

  // State encoding kept identical to the carry-less multiply unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bit_cldiv_state_type;

  // Bit-manip op bits driving this unit.
  typedef struct packed {
    logic bit_cldiv;
    logic bit_clrem;
  } bit_op_type;

  typedef struct packed {
    logic                  enable;
    bit_op_type            op;
    logic [CLDIV_XLEN-1:0] rdata1;
    logic [CLDIV_XLEN-1:0] rdata2;
  } bit_cldiv_in_type;

  typedef struct packed {
    logic [CLDIV_XLEN-1:0] result;
    logic                  ready;
  } bit_cldiv_out_type;

  typedef struct packed {
    bit_cldiv_state_type    state;
    logic [CLDIV_CNT_W-1:0] counter;
    logic [CLDIV_CNT_W-1:0] deg;
    bit_op_type             op;
    logic [CLDIV_XLEN-1:0]  dividend;
    logic [CLDIV_XLEN-1:0]  divisor;
    logic [CLDIV_XLEN-1:0]  quot;
    logic [CLDIV_XLEN-1:0]  rem;
    logic [CLDIV_XLEN-1:0]  result;
    logic                   ready;
  } bit_cldiv_reg_type;

  localparam bit_cldiv_reg_type init_bit_cldiv_reg = '{
    state:    IDLE,
    counter:  '0,
    deg:      '0,
    op:       '0,
    dividend: '0,
    divisor:  '0,
    quot:     '0,
    rem:      '0,
    result:   '0,
    ready:    1'b0
  };

  // Leading-one priority encoder: index of the most significant set bit.
  // Returns 0 for a zero input; callers treat zero divisors separately.
  function automatic logic [CLDIV_CNT_W-1:0] deg(input logic [CLDIV_XLEN-1:0] v);
    logic [CLDIV_CNT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < CLDIV_XLEN; i++) begin
      if (v[i]) idx = CLDIV_CNT_W'(i);
    end
    return idx;
  endfunction

  // Pick the architectural result; quotient has priority if both are set.
  function automatic logic [CLDIV_XLEN-1:0] sel_result(input bit_op_type op,
                                                       input logic [CLDIV_XLEN-1:0] quot,
                                                       input logic [CLDIV_XLEN-1:0] rem);
    logic [CLDIV_XLEN-1:0] res;
    res = '0;
    if (op.bit_cldiv)      res = quot;
    else if (op.bit_clrem) res = rem;
    return res;
  endfunction

endpackage

// File: rtl/bit_cldiv.sv
// Iterative GF(2) polynomial divider: one quotient bit per cycle, MSB first.
module bit_cldiv
  import bit_cldiv_pkg::*;
#(
  parameter int XLEN = CLDIV_XLEN  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            op_cldiv,
  input  logic            op_clrem,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] result,
  output logic            ready
);

  bit_cldiv_in_type  d;
  bit_cldiv_out_type o;
  bit_cldiv_reg_type r;

  logic [XLEN-1:0] w;
  logic            hit;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quot_step;

  // Pack inputs; quotient wins if both op bits are raised together.
  always_comb begin
    d           = '0;
    d.enable    = enable;
    d.op.bit_cldiv = op_cldiv;
    d.op.bit_clrem = op_clrem & ~op_cldiv;
    d.rdata1    = rdata1;
    d.rdata2    = rdata2;
  end

  // One long-division step: bring down the next dividend bit and subtract
  // (xor) the divisor whenever the partial remainder reaches its degree.
  // deg(rem) < deg(divisor) holds before the shift, so w never overflows.
  always_comb begin
    w         = {r.rem[XLEN-2:0], r.dividend[r.counter]};
    hit       = w[r.deg];
    rem_step  = hit ? (w ^ r.divisor) : w;
    quot_step = r.quot;
    quot_step[r.counter] = hit;
  end

  // Control FSM plus datapath registers; result/ready are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= init_bit_cldiv_reg;
    end else begin
      r.ready <= 1'b0;
      unique case (r.state)
        IDLE: begin
          if (d.enable && (d.op.bit_cldiv || d.op.bit_clrem)) begin
            r.dividend <= d.rdata1;
            r.divisor  <= d.rdata2;
            r.op       <= d.op;
            r.deg      <= deg(d.rdata2);
            r.quot     <= '0;
            r.rem      <= '0;
            r.counter  <= '1;
            if (d.rdata2 == '0) begin
              // Division by zero: quotient 0, remainder is the dividend.
              r.rem    <= d.rdata1;
              r.result <= sel_result(d.op, '0, d.rdata1);
              r.ready  <= 1'b1;
              r.state  <= DONE;
            end else begin
              r.state  <= BUSY;
            end
          end
        end
        BUSY: begin
          r.rem  <= rem_step;
          r.quot <= quot_step;
          if (r.counter == '0) begin
            r.result <= sel_result(r.op, quot_step, rem_step);
            r.ready  <= 1'b1;
            r.state  <= DONE;
          end else begin
            r.counter <= r.counter - 1'b1;
          end
        end
        DONE: begin
          r.state <= IDLE;
        end
        default: begin
          r.state <= IDLE;
        end
      endcase
    end
  end

  // Drive outputs straight from registers.
  always_comb begin
    o        = '0;
    o.result = r.result;
    o.ready  = r.ready;
  end

  assign result = o.result;
  assign ready  = o.ready;

endmodule
